// File: rtl/srp16_dbg_pkg.sv
// Shared types and default widths for the SRP16 run/dump controller.
package srp16_dbg_pkg;

  localparam int unsigned DefAddrW = 16;
  localparam int unsigned DefDataW = 16;
  localparam int unsigned NcycW    = 32;

  typedef enum logic [2:0] {
    StIdle,
    StCrst,
    StRun,
    StDreq,
    StDwait,
    StDout,
    StDone
  } rc_state_t;

endpackage

// File: rtl/rc_down_counter.sv
// Loadable down-counter with zero flag; times both the core-reset and run phases.
module rc_down_counter
  import srp16_dbg_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [NcycW-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [NcycW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - NcycW'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/srp16_run_controller.sv
// Run/dump controller: holds the SRP16 core in reset, runs it for a bounded
// number of cycles, then streams a window of data memory over valid/ready.
module srp16_run_controller
  import srp16_dbg_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NcycW-1:0]  n_cycles,
  input  logic [ADDR_W-1:0] dump_addr,
  input  logic [ADDR_W:0]   dump_size,
  output logic              core_reset,
  output logic              core_en,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic [ADDR_W-1:0] dout_addr,
  output logic              dout_last,
  output logic              busy,
  output logic              done
);

  rc_state_t state_q, state_d;

  logic [NcycW-1:0]  ncyc_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   rem_q;
  logic [DATA_W-1:0] dout_data_q;
  logic [ADDR_W-1:0] dout_addr_q;
  logic              dout_last_q;

  logic             cnt_load;
  logic [NcycW-1:0] cnt_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             latch;
  logic             capture;
  logic             handshake;
  logic             last_word;

  assign last_word = (rem_q == (ADDR_W+1)'(1));

  rc_down_counter u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_dec   = 1'b0;
    latch     = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          latch    = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = NcycW'(RST_CYCLES - 1);
          state_d  = StCrst;
        end
      end
      StCrst: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (ncyc_q == '0) begin
          // Nothing to run and nothing to dump: skip straight to DONE.
          state_d = (rem_q == '0) ? StDone : StDreq;
        end else begin
          cnt_load = 1'b1;
          cnt_val  = ncyc_q - NcycW'(1);
          state_d  = StRun;
        end
      end
      StRun: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          state_d = (rem_q == '0) ? StDone : StDreq;
        end
      end
      StDreq:  state_d = StDwait;
      StDwait: begin
        capture = 1'b1;
        state_d = StDout;
      end
      StDout: begin
        if (dout_ready) begin
          handshake = 1'b1;
          state_d   = last_word ? StDone : StDreq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ncyc_q      <= '0;
      ptr_q       <= '0;
      rem_q       <= '0;
      dout_data_q <= '0;
      dout_addr_q <= '0;
      dout_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        ncyc_q <= n_cycles;
        ptr_q  <= dump_addr;
        rem_q  <= dump_size;
      end
      if (capture) begin
        dout_data_q <= mem_rdata;
        dout_addr_q <= ptr_q;
        dout_last_q <= last_word;
      end
      if (handshake) begin
        ptr_q <= ptr_q + ADDR_W'(1);
        rem_q <= rem_q - (ADDR_W+1)'(1);
      end
    end
  end

  assign core_reset = (state_q == StIdle) || (state_q == StCrst);
  assign core_en    = (state_q == StRun);
  assign mem_rd     = (state_q == StDreq);
  assign mem_addr   = ptr_q;
  assign dout_valid = (state_q == StDout);
  assign dout_data  = dout_data_q;
  assign dout_addr  = dout_addr_q;
  assign dout_last  = dout_last_q;
  assign done       = (state_q == StDone);
  assign busy       = (state_q != StIdle) && (state_q != StDone);

endmodule

// File: tb/tb_srp16_run_controller.sv
// Randomised bench: each run is checked cycle by cycle against a timeline
// derived from the run parameters (reset, run, then 3-cycle-per-word dump).
module tb_srp16_run_controller;

  localparam int unsigned RstCycles = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] n_cycles;
  logic [15:0] dump_addr;
  logic [16:0] dump_size;
  logic        core_reset;
  logic        core_en;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        dout_valid;
  logic        dout_ready;
  logic [15:0] dout_data;
  logic [15:0] dout_addr;
  logic        dout_last;
  logic        busy;
  logic        done;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] key;

  srp16_run_controller #(
    .ADDR_W     (16),
    .DATA_W     (16),
    .RST_CYCLES (RstCycles)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .n_cycles   (n_cycles),
    .dump_addr  (dump_addr),
    .dump_size  (dump_size),
    .core_reset (core_reset),
    .core_en    (core_en),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .dout_addr  (dout_addr),
    .dout_last  (dout_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Memory image: word at address a holds a + key, one cycle read latency.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem_addr + key;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string where);
    check({where, ":core_reset"}, core_reset, 1);
    check({where, ":core_en"}, core_en, 0);
    check({where, ":mem_rd"}, mem_rd, 0);
    check({where, ":mem_addr"}, mem_addr, 0);
    check({where, ":dout_valid"}, dout_valid, 0);
    check({where, ":dout_data"}, dout_data, 0);
    check({where, ":dout_addr"}, dout_addr, 0);
    check({where, ":dout_last"}, dout_last, 0);
    check({where, ":busy"}, busy, 0);
    check({where, ":done"}, done, 0);
  endtask

  task automatic check_done(input string where);
    check({where, ":done"}, done, 1);
    check({where, ":busy"}, busy, 0);
    check({where, ":core_en"}, core_en, 0);
    check({where, ":core_reset"}, core_reset, 0);
    check({where, ":mem_rd"}, mem_rd, 0);
    check({where, ":dout_valid"}, dout_valid, 0);
  endtask

  // Start a run from IDLE/DONE and follow it to DONE (or to an injected reset).
  task automatic run_txn(input logic [31:0] n, input logic [15:0] addr, input logic [16:0] size,
                         input int stall_max, input int force_k, input int force_len,
                         input bit poke, input int abort_k);
    logic [15:0] a;
    int          stall;
    start     = 1'b1;
    n_cycles  = n;
    dump_addr = addr;
    dump_size = size;
    step();
    // Scramble inputs so any late sampling shows up.
    start     = 1'b0;
    n_cycles  = $urandom;
    dump_addr = 16'($urandom);
    dump_size = 17'($urandom);
    for (int i = 0; i < int'(RstCycles); i++) begin
      check($sformatf("crst%0d:core_reset", i), core_reset, 1);
      check($sformatf("crst%0d:core_en", i), core_en, 0);
      check($sformatf("crst%0d:busy", i), busy, 1);
      check($sformatf("crst%0d:done", i), done, 0);
      check($sformatf("crst%0d:mem_rd", i), mem_rd, 0);
      step();
    end
    for (int i = 0; i < int'(n); i++) begin
      check($sformatf("run%0d:core_en", i), core_en, 1);
      check($sformatf("run%0d:core_reset", i), core_reset, 0);
      check($sformatf("run%0d:busy", i), busy, 1);
      check($sformatf("run%0d:mem_rd", i), mem_rd, 0);
      if (poke && i == 0) begin
        start    = 1'b1;
        n_cycles = n + 32'd5;
      end
      step();
      start = 1'b0;
    end
    if (size == '0) begin
      check_done("nodump");
      return;
    end
    a = addr;
    for (int k = 0; k < int'(size); k++) begin
      check($sformatf("w%0d:req_mem_rd", k), mem_rd, 1);
      check($sformatf("w%0d:mem_addr", k), mem_addr, a);
      check($sformatf("w%0d:req_valid", k), dout_valid, 0);
      check($sformatf("w%0d:req_core_en", k), core_en, 0);
      dout_ready = 1'($urandom);
      step();
      check($sformatf("w%0d:wait_mem_rd", k), mem_rd, 0);
      check($sformatf("w%0d:wait_valid", k), dout_valid, 0);
      dout_ready = 1'($urandom);
      step();
      stall = (k == force_k) ? force_len : int'($urandom_range(0, stall_max));
      for (int s = 0; s <= stall; s++) begin
        check($sformatf("w%0d.%0d:valid", k, s), dout_valid, 1);
        check($sformatf("w%0d.%0d:data", k, s), dout_data, 16'(a + key));
        check($sformatf("w%0d.%0d:addr", k, s), dout_addr, a);
        check($sformatf("w%0d.%0d:last", k, s), dout_last, (k == int'(size) - 1));
        check($sformatf("w%0d.%0d:mem_rd", k, s), mem_rd, 0);
        check($sformatf("w%0d.%0d:busy", k, s), busy, 1);
        if (k == abort_k) begin
          reset      = 1'b1;
          dout_ready = 1'b1;
          step();
          reset      = 1'b0;
          dout_ready = 1'b0;
          check_reset_state("abort");
          step();
          check_reset_state("abort_idle");
          return;
        end
        dout_ready = (s == stall);
        step();
      end
      dout_ready = 1'b0;
      a = a + 16'd1;
    end
    check_done("end");
    for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
      step();
      check_done("hold");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, sz, ab;
    logic [15:0] ad;
    reset      = 1'b1;
    start      = 1'b0;
    n_cycles   = '0;
    dump_addr  = '0;
    dump_size  = '0;
    dout_ready = 1'b0;
    key        = 16'h1000;
    step();
    start = 1'b1;  // reset must win over a simultaneous start
    step();
    check_reset_state("reset");
    reset = 1'b0;
    start = 1'b0;
    step();
    check_reset_state("idle");

    run_txn(32'd5, 16'h0000, 17'd0, 0, -1, 0, 1'b0, -1);
    run_txn(32'd3, 16'h0010, 17'd4, 0, -1, 0, 1'b0, -1);
    run_txn(32'd2, 16'hFFFE, 17'd3, 0, -1, 0, 1'b0, -1);
    run_txn(32'd1, 16'h0100, 17'd3, 0, 1, 7, 1'b0, -1);
    run_txn(32'd4, 16'h0200, 17'd3, 0, -1, 0, 1'b1, 1);
    run_txn(32'd0, 16'h0300, 17'd1, 0, -1, 0, 1'b0, -1);
    run_txn(32'd0, 16'h0400, 17'd0, 0, -1, 0, 1'b0, -1);

    for (int r = 0; r < 40; r++) begin
      key = 16'($urandom);
      n   = int'($urandom_range(0, 6));
      sz  = int'($urandom_range(0, 5));
      ad  = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
      ab  = ($urandom_range(0, 7) == 0 && sz > 0) ? int'($urandom_range(0, sz - 1)) : -1;
      run_txn(32'(n), ad, 17'(sz), 3, -1, 0, 1'($urandom), ab);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/srp16_run_controller.md
# srp16_run_controller

Hardware run/dump controller for the SRP16 processor. It holds the core in reset, releases it, and enables it for a programmed number of clock cycles. It then freezes the core and streams a contiguous window of data memory out over a valid/ready port. It sits between the SRP16_processor (core reset and clock enable) and the data memory's spare read port, so host or debug logic can perform a bounded run followed by a memory dump in silicon.

## Interface
- ADDR_W, 16, data-memory word-address width
- DATA_W, 16, memory word width
- RST_CYCLES, 2, cycles core_reset stays asserted after start (≥1)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; ignored while busy=1
- n_cycles  in  32  core-enabled cycle count, latched on start
- dump_addr  in  ADDR_W  first word address, latched on start
- dump_size  in  ADDR_W+1  number of words to dump, latched on start
- core_reset  out  1  reset to SRP16 core
- core_en  out  1  clock enable to SRP16 core
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory read address
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_rd
- dout_valid  out  1  dump word available
- dout_ready  in  1  consumer accepts word
- dout_data  out  DATA_W  dump word
- dout_addr  out  ADDR_W  address of dout_data
- dout_last  out  1  final word of dump, qualified by dout_valid
- busy  out  1  high in every state except IDLE/DONE
- done  out  1  high in DONE

## Operation
- States: IDLE, CRST, RUN, DREQ, DWAIT, DOUT, DONE.
- Reset values: state=IDLE, core_reset=1, core_en=0, mem_rd=0, mem_addr=0, dout_valid=0, dout_data=0, dout_addr=0, dout_last=0, busy=0, done=0.
- IDLE: core_reset=1. On start, latch inputs and go to CRST.
- CRST: core_reset=1 for RST_CYCLES cycles. Then go to RUN, or go to DREQ if n_cycles=0.
- RUN: core_reset=0, core_en=1 for exactly n_cycles cycles, then go to DREQ. If dump_size=0, go directly to DONE.
- After RUN, core_en=0 and core_reset=0: core state is frozen, not reset.
- DREQ: mem_rd=1, mem_addr=current pointer, then go to DWAIT.
- DWAIT: capture mem_rdata into dout_data and the pointer into dout_addr. Set dout_last if this is the final word. Go to DOUT.
- DOUT: dout_valid=1 and data is held stable until dout_ready. On the handshake, increment the pointer and decrement the remaining count. Go to DREQ, or to DONE after the last word.
- Pointer arithmetic is modulo 2^ADDR_W: 0xFFFF+1 wraps to 0x0000. dump_size up to 2^ADDR_W is legal.
- DONE: done=1, core stays frozen. A start here behaves as from IDLE: core_reset reasserts the cycle after start and new inputs are latched.
- start while busy: ignored, latched values unchanged.
- reset at any time: all outputs take their reset values on the next edge and any in-flight dump is abandoned with no further dout_valid. reset wins over a simultaneous start.

## Timing
- start sampled at edge E: busy=1 and core_reset=1 from E+1 for RST_CYCLES cycles. core_en=1 for the next n_cycles cycles.
- First mem_rd in the cycle after the last core_en cycle, or the cycle after CRST when n_cycles=0.
- Per word: mem_rd in cycle D, dout_valid from cycle D+2. The handshake cycle H is followed by the next mem_rd in H+1. Throughput is 3 cycles/word with ready held high.
- done=1 in the cycle after the final handshake. busy and done are never both 1.
- mem_rd is a single-cycle pulse, and at most one read is outstanding.

## Structure
- Package srp16_dbg_pkg holds the state enum (rc_state_t), the default ADDR_W/DATA_W constants and the n_cycles width.
- One sub-module, rc_down_counter: a loadable 32-bit down-counter with a zero flag. It is shared by CRST (load RST_CYCLES) and RUN (load n_cycles).
- Everything else is inline: FSM, address pointer, remaining-word count, output register.

## Test plan
- RST_CYCLES=2, n_cycles=5, dump_size=0, start at cycle 10 -> core_reset=1 in cycles 11–12, core_en=1 in exactly cycles 13–17, done=1 at cycle 18, mem_rd never asserted.
- n_cycles=3, dump_addr=0x0010, dump_size=4, memory word = address+0x1000, ready tied high -> words 0x1010..0x1013 at dout_addr 0x10..0x13, dout_last on 0x1013 only, 3 cycles apart.
- dump_addr=0xFFFE, dump_size=3 -> dout_addr sequence 0xFFFE, 0xFFFF, 0x0000.
- dout_ready low for 7 cycles on the second word -> dout_data/dout_addr stable and no extra mem_rd while stalled. Single transfer only.
- start pulsed again during RUN with different n_cycles -> ignored, original count completes. Then reset asserted in DOUT -> next cycle dout_valid=0, core_reset=1, state IDLE.
- n_cycles=0, dump_size=1 -> core_en never 1, first mem_rd the cycle after CRST, done after one handshake. A start in DONE reasserts core_reset the following cycle.
